ps2_key_decoder: RTL and testbench

Registered PS/2 scancode decoder sitting between `PS2_Controller` and `MonumentValley`. It replaces the top-level combinational move/dir decoding. It parses Set-2 make, break (`F0`) and extended (`E0`) sequences, tracks which direction keys are held, and issues clean single-cycle `move` and `activate` pulses with a registered `dir`. It optionally auto-repeats `move` while a direction key is held.

---
 rtl/ps2_key_decoder.sv | 163 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// Registered PS/2 Set-2 scancode decoder: direction key tracking, move/activate pulses, optional auto-repeat.
// Optional auto-repeat of move while a direction key is held: define KEYDEC_AUTOREPEAT_EN.
module ps2_key_decoder #(
   parameter int          REPEAT_CYCLES = 12500000,
   parameter int          REPEAT_W      = 24,
   parameter logic [7:0]  ACT_CODE      = 8'h29
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic [7:0] data,
   input  logic       data_en,
   output logic       move,
   output logic [1:0] dir,
   output logic       activate,
   output logic [3:0] held,
   output logic       prefix_busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK} state_t;

   localparam logic [REPEAT_W-1:0] LP_REPEAT_MAX = REPEAT_W'(REPEAT_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_move;
   logic       r_act;
   logic       r_busy;
   logic [1:0] r_dir;
   logic [3:0] r_held;

   logic       w_ext;
   logic       w_mk;
   logic       w_bk;
   logic       w_act_hit;
   logic       w_key_vld;
   logic [1:0] w_key;
   logic       w_dir_make;
   logic       w_dir_brk;
   logic       w_brk_cur;
   logic [3:0] w_remain;
   logic [1:0] w_hi;
   logic       w_tick;

   // Returns {valid, dir code}; extended codes only match after an E0 prefix.
   function automatic logic [2:0] map_code(input logic [7:0] code, input logic ext);
      logic [2:0] res;
      res = 3'b000;
      if (!ext) begin
         case (code)
            8'h1D:   res = 3'b111;
            8'h1C:   res = 3'b101;
            8'h1B:   res = 3'b100;
            8'h23:   res = 3'b110;
            default: res = 3'b000;
         endcase
      end else begin
         case (code)
            8'h75:   res = 3'b111;
            8'h6B:   res = 3'b101;
            8'h72:   res = 3'b100;
            8'h74:   res = 3'b110;
            default: res = 3'b000;
         endcase
      end
      return res;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_mk        = 1'b0;
      w_bk        = 1'b0;
      w_act_hit   = 1'b0;
      if (data_en) begin
         case (r_state)
            S_IDLE: begin
               if (data == 8'hE0)      w_state_nxt = S_EXT;
               else if (data == 8'hF0) w_state_nxt = S_BRK;
               else begin
                  w_mk      = 1'b1;
                  w_act_hit = (data == ACT_CODE);
               end
            end
            S_EXT: begin
               if (data == 8'hF0) w_state_nxt = S_EXTBRK;
               else begin
                  w_mk        = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            S_BRK, S_EXTBRK: begin
               w_bk        = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_ext                = (r_state == S_EXT) || (r_state == S_EXTBRK);
   assign {w_key_vld, w_key}   = map_code(data, w_ext);
   assign w_dir_make           = w_mk & w_key_vld & ~r_held[w_key];
   assign w_dir_brk            = w_bk & w_key_vld & r_held[w_key];
   assign w_remain             = r_held & ~(4'b0001 << w_key);
   assign w_brk_cur            = w_dir_brk & (w_key == r_dir) & (|w_remain);

   always_comb begin
      w_hi = 2'b00;
      if (w_remain[3])      w_hi = 2'b11;
      else if (w_remain[2]) w_hi = 2'b10;
      else if (w_remain[1]) w_hi = 2'b01;
   end

`ifdef KEYDEC_AUTOREPEAT_EN
   logic [REPEAT_W-1:0] r_rpt_cnt;

   // A tick is suppressed when the current key is being released this cycle.
   assign w_tick = r_held[r_dir] & (r_rpt_cnt == LP_REPEAT_MAX)
                   & ~(w_dir_brk & (w_key == r_dir));
`else
   logic w_unused_cfg;
   assign w_unused_cfg = ^LP_REPEAT_MAX;
   assign w_tick       = 1'b0;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_move  <= 1'b0;
         r_act   <= 1'b0;
         r_busy  <= 1'b0;
         r_dir   <= 2'b00;
         r_held  <= 4'b0000;
`ifdef KEYDEC_AUTOREPEAT_EN
         r_rpt_cnt <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_act   <= w_act_hit;
         r_move  <= w_dir_make | w_tick;
         if (w_dir_make) begin
            r_held[w_key] <= 1'b1;
            r_dir         <= w_key;
         end else if (w_dir_brk) begin
            r_held[w_key] <= 1'b0;
            if (w_brk_cur) r_dir <= w_hi;
         end
`ifdef KEYDEC_AUTOREPEAT_EN
         if (w_dir_make || w_brk_cur || !r_held[r_dir] || w_tick)
            r_rpt_cnt <= '0;
         else
            r_rpt_cnt <= r_rpt_cnt + 1'b1;
`endif
      end
   end

   assign move        = r_move;
   assign dir         = r_dir;
   assign activate    = r_act;
   assign held        = r_held;
   assign prefix_busy = r_busy;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; covers make/break/extended parsing, priority fallback, activate and reset.
module tb_ps2_key_decoder;

   logic       clock;
   logic       resetn;
   logic [7:0] data;
   logic       data_en;
   logic       move;
   logic [1:0] dir;
   logic       activate;
   logic [3:0] held;
   logic       prefix_busy;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int cyc       = 0;
   int move_cnt  = 0;
   int act_cnt   = 0;
   int consec    = 0;
   logic prev_move = 1'b0;
   logic prev_act  = 1'b0;
   int move_t[$];

   ps2_key_decoder #(.REPEAT_CYCLES(8), .REPEAT_W(4), .ACT_CODE(8'h29)) dut (
      .clock(clock), .resetn(resetn), .data(data), .data_en(data_en),
      .move(move), .dir(dir), .activate(activate), .held(held),
      .prefix_busy(prefix_busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      cyc = cyc + 1;
      if (move) begin
         move_cnt = move_cnt + 1;
         move_t.push_back(cyc);
      end
      if (activate) act_cnt = act_cnt + 1;
      if ((move && prev_move) || (activate && prev_act)) consec = consec + 1;
      prev_move = move;
      prev_act  = activate;
   end

   task automatic send(input logic [7:0] b);
      @(negedge clock);
      data    = b;
      data_en = 1'b1;
      @(negedge clock);
      data_en = 1'b0;
      data    = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clock);
   endtask

   task automatic test_reset;
      resetn = 1'b0; data = 8'h00; data_en = 1'b0;
      idle(3);
      check_cnt++; if (move !== 1'b0) $display("FAIL reset_move got %b want 0", move); else pass_cnt++;
      check_cnt++; if (activate !== 1'b0) $display("FAIL reset_act got %b want 0", activate); else pass_cnt++;
      check_cnt++; if (dir !== 2'b00) $display("FAIL reset_dir got %b want 00", dir); else pass_cnt++;
      check_cnt++; if (held !== 4'b0000) $display("FAIL reset_held got %b want 0000", held); else pass_cnt++;
      check_cnt++; if (prefix_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", prefix_busy); else pass_cnt++;
      resetn = 1'b1;
      idle(2);
   endtask

   task automatic test_make_up;
      send(8'h1D);
      check_cnt++; if (move !== 1'b1) $display("FAIL up_move got %b want 1", move); else pass_cnt++;
      check_cnt++; if (dir !== 2'b11) $display("FAIL up_dir got %b want 11", dir); else pass_cnt++;
      check_cnt++; if (held !== 4'b1000) $display("FAIL up_held got %b want 1000", held); else pass_cnt++;
      idle(1);
      check_cnt++; if (move !== 1'b0) $display("FAIL up_move_width got %b want 0", move); else pass_cnt++;
      send(8'hF0); send(8'h1D);
      check_cnt++; if (held !== 4'b0000) $display("FAIL up_break_held got %b want 0000", held); else pass_cnt++;
      idle(2);
   endtask

   task automatic test_extended;
      int base;
      base = move_cnt;
      send(8'hE0);
      check_cnt++; if (prefix_busy !== 1'b1) $display("FAIL ext_busy got %b want 1", prefix_busy); else pass_cnt++;
      send(8'h6B);
      check_cnt++; if (move !== 1'b1) $display("FAIL ext_move got %b want 1", move); else pass_cnt++;
      check_cnt++; if (dir !== 2'b01) $display("FAIL ext_dir got %b want 01", dir); else pass_cnt++;
      check_cnt++; if (held !== 4'b0010) $display("FAIL ext_held got %b want 0010", held); else pass_cnt++;
      check_cnt++; if (prefix_busy !== 1'b0) $display("FAIL ext_busy_idle got %b want 0", prefix_busy); else pass_cnt++;
      send(8'hE0); send(8'hF0);
      check_cnt++; if (prefix_busy !== 1'b1) $display("FAIL extbrk_busy got %b want 1", prefix_busy); else pass_cnt++;
      send(8'h6B);
      check_cnt++; if (held !== 4'b0000) $display("FAIL extbrk_held got %b want 0000", held); else pass_cnt++;
      check_cnt++; if (dir !== 2'b01) $display("FAIL extbrk_dir got %b want 01", dir); else pass_cnt++;
      idle(3);
      check_cnt++; if (move_cnt - base !== 1) $display("FAIL ext_move_count got %0d want 1", move_cnt - base); else pass_cnt++;
   endtask

   task automatic test_switch;
      int base;
      base = move_cnt;
      send(8'h1B);
      check_cnt++; if (dir !== 2'b00) $display("FAIL sw_dir_down got %b want 00", dir); else pass_cnt++;
      send(8'h23);
      check_cnt++; if (dir !== 2'b10) $display("FAIL sw_dir_right got %b want 10", dir); else pass_cnt++;
      check_cnt++; if (held !== 4'b0101) $display("FAIL sw_held2 got %b want 0101", held); else pass_cnt++;
      send(8'hF0); send(8'h23);
      check_cnt++; if (dir !== 2'b00) $display("FAIL sw_fallback_dir got %b want 00", dir); else pass_cnt++;
      check_cnt++; if (held !== 4'b0001) $display("FAIL sw_fallback_held got %b want 0001", held); else pass_cnt++;
      idle(2);
      check_cnt++; if (move_cnt - base !== 2) $display("FAIL sw_move_count got %0d want 2", move_cnt - base); else pass_cnt++;
      send(8'h1C); send(8'h1D);
      check_cnt++; if (held !== 4'b1011) $display("FAIL prio_held got %b want 1011", held); else pass_cnt++;
      send(8'hF0); send(8'h1D);
      check_cnt++; if (dir !== 2'b01) $display("FAIL prio_dir_left got %b want 01", dir); else pass_cnt++;
      send(8'hF0); send(8'h1C);
      check_cnt++; if (dir !== 2'b00) $display("FAIL prio_dir_down got %b want 00", dir); else pass_cnt++;
      send(8'hF0); send(8'h1B);
      check_cnt++; if (held !== 4'b0000) $display("FAIL sw_clear_held got %b want 0000", held); else pass_cnt++;
      idle(2);
      check_cnt++; if (move_cnt - base !== 4) $display("FAIL prio_move_count got %0d want 4", move_cnt - base); else pass_cnt++;
   endtask

   task automatic test_typematic;
      int base;
      int qb;
      base = move_cnt;
      qb   = move_t.size();
      for (int i = 0; i < 5; i++) send(8'h1D);
      idle(20);
`ifdef KEYDEC_AUTOREPEAT_EN
      check_cnt++;
      if (move_t.size() - qb < 3) $display("FAIL rpt_count got %0d want >=3", move_t.size() - qb);
      else pass_cnt++;
      if (move_t.size() - qb >= 3) begin
         check_cnt++; if (move_t[qb+1] - move_t[qb] !== 8) $display("FAIL rpt_gap1 got %0d want 8", move_t[qb+1] - move_t[qb]); else pass_cnt++;
         check_cnt++; if (move_t[qb+2] - move_t[qb+1] !== 8) $display("FAIL rpt_gap2 got %0d want 8", move_t[qb+2] - move_t[qb+1]); else pass_cnt++;
      end
`else
      check_cnt++; if (move_cnt - base !== 1) $display("FAIL typ_move_count got %0d want 1 (queue %0d)", move_cnt - base, move_t.size() - qb); else pass_cnt++;
`endif
      check_cnt++; if (held !== 4'b1000) $display("FAIL typ_held got %b want 1000", held); else pass_cnt++;
      send(8'hF0); send(8'h1D);
      base = move_cnt;
      idle(20);
      check_cnt++; if (move_cnt - base !== 0) $display("FAIL typ_after_break got %0d want 0", move_cnt - base); else pass_cnt++;
      check_cnt++; if (held !== 4'b0000) $display("FAIL typ_break_held got %b want 0000", held); else pass_cnt++;
   endtask

   task automatic test_activate;
      int mb;
      int ab;
      mb = move_cnt;
      ab = act_cnt;
      send(8'h29);
      check_cnt++; if (activate !== 1'b1) $display("FAIL act_pulse got %b want 1", activate); else pass_cnt++;
      idle(1);
      check_cnt++; if (activate !== 1'b0) $display("FAIL act_width got %b want 0", activate); else pass_cnt++;
      send(8'hFA); send(8'hF0); send(8'h29); send(8'hE0); send(8'h29);
      send(8'hF0); send(8'h1C);
      idle(2);
      check_cnt++; if (act_cnt - ab !== 1) $display("FAIL act_count got %0d want 1", act_cnt - ab); else pass_cnt++;
      check_cnt++; if (move_cnt - mb !== 0) $display("FAIL act_moves got %0d want 0", move_cnt - mb); else pass_cnt++;
      check_cnt++; if (held !== 4'b0000) $display("FAIL act_held got %b want 0000", held); else pass_cnt++;
      check_cnt++; if (dir !== 2'b11) $display("FAIL act_dir got %b want 11", dir); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int mb;
      mb = move_cnt;
      send(8'hE0); send(8'hF0);
      check_cnt++; if (prefix_busy !== 1'b1) $display("FAIL mid_busy got %b want 1", prefix_busy); else pass_cnt++;
      resetn = 1'b0;
      #1;
      check_cnt++; if (prefix_busy !== 1'b0) $display("FAIL mid_async got %b want 0", prefix_busy); else pass_cnt++;
      @(negedge clock);
      resetn = 1'b1;
      send(8'h75);
      idle(2);
      check_cnt++; if (held !== 4'b0000) $display("FAIL mid_held got %b want 0000", held); else pass_cnt++;
      check_cnt++; if (move_cnt - mb !== 0) $display("FAIL mid_moves got %0d want 0", move_cnt - mb); else pass_cnt++;
      check_cnt++; if (prefix_busy !== 1'b0) $display("FAIL mid_busy_end got %b want 0", prefix_busy); else pass_cnt++;
   endtask

   initial begin
      resetn  = 1'b0;
      data    = 8'h00;
      data_en = 1'b0;
      test_reset();
      test_make_up();
      test_extended();
      test_switch();
      test_typematic();
      test_activate();
      test_reset_mid();
      check_cnt++; if (consec !== 0) $display("FAIL pulse_consecutive got %0d want 0", consec); else pass_cnt++;
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
